// File: rtl/sysid_ext_slave.sv
// System-ID slave: build ID/timestamp, snapshot-coherent 64-bit uptime counter and
// scratch registers behind an Avalon-MM port with a fixed-latency read return pipe.
module sysid_ext_slave #(
  parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP_VALUE = 32'h0000_0000,
  parameter int          NUM_SCRATCH     = 2,
  parameter int          READ_LATENCY    = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] NS = 3'(NUM_SCRATCH);

  logic [63:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic        run_q, run_d;
  logic [31:0] scr_q [4];
  logic [31:0] scr_d [4];

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [31:0]             dat_q [READ_LATENCY];
  logic [31:0]             dat_d [READ_LATENCY];

  logic [2:0]  scr_off;
  logic        scr_hit;
  logic        ctrl_we;
  logic [31:0] rd_word;

  always_comb begin
    scr_off = address - 3'd5;
    scr_hit = (address >= 3'd5) && (scr_off < NS);
    ctrl_we = write && (address == 3'd4) && byteenable[0];
  end

  // Read data is taken from the current register outputs, so a same-cycle write is not seen.
  always_comb begin
    rd_word = '0;
    case (address)
      3'd0:    rd_word = ID_VALUE;
      3'd1:    rd_word = TIMESTAMP_VALUE;
      3'd2:    rd_word = cnt_q[31:0];
      3'd3:    rd_word = hi_q;
      3'd4:    rd_word = {30'd0, run_q, 1'b0};
      default: if (scr_hit) rd_word = scr_q[scr_off[1:0]];
    endcase
  end

  always_comb begin
    run_d = ctrl_we ? writedata[1] : run_q;
    if (ctrl_we && writedata[0]) begin
      cnt_d = '0;
    end else if (run_q) begin
      cnt_d = cnt_q + 64'd1;
    end else begin
      cnt_d = cnt_q;
    end
    // Upper half is frozen alongside the low-word read so the pair stays coherent.
    hi_d = (read && (address == 3'd2)) ? cnt_q[63:32] : hi_q;
    for (int i = 0; i < 4; i++) begin
      scr_d[i] = scr_q[i];
      if (write && scr_hit && (scr_off[1:0] == 2'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) scr_d[i][8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
  end

  // Data lane carries zero on idle slots, so readdata is 0 whenever readdatavalid is 0.
  always_comb begin
    vld_d[0] = read;
    dat_d[0] = read ? rd_word : '0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      run_q <= 1'b1;
      vld_q <= '0;
      for (int i = 0; i < 4; i++) scr_q[i] <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      run_q <= run_d;
      vld_q <= vld_d;
      for (int i = 0; i < 4; i++) scr_q[i] <= scr_d[i];
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign readdata      = dat_q[READ_LATENCY-1];
  assign readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_ext_slave.sv
// Bench for sysid_ext_slave: scoreboard of expected read returns checked on readdatavalid,
// plus a small uptime-counter model; a second instance exercises READ_LATENCY=3.
module tb_sysid_ext_slave;
  localparam logic [31:0] ID = 32'h5D1C_A14E;
  localparam logic [31:0] TS = 32'h6554_3210;
  localparam int RL  = 2;
  localparam int RL3 = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata, readdata3;
  logic        readdatavalid, readdatavalid3;

  sysid_ext_slave #(.ID_VALUE(ID), .TIMESTAMP_VALUE(TS), .NUM_SCRATCH(2), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .readdatavalid(readdatavalid));

  sysid_ext_slave #(.ID_VALUE(ID), .TIMESTAMP_VALUE(TS), .NUM_SCRATCH(2), .READ_LATENCY(RL3)) dut3 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata3),
    .readdatavalid(readdatavalid3));

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Uptime counter / shadow reference model, sampled on the same edges as the DUT.
  logic [63:0] m_cnt = '0;
  logic [31:0] m_hi = '0;
  logic        m_run = 1'b1;
  logic        m_preload = 1'b0;
  logic [63:0] m_preload_val = '0;
  logic [63:0] m_cur;
  logic        m_ctrl_we;

  assign m_cur     = m_preload ? m_preload_val : m_cnt;
  assign m_ctrl_we = write && (address == 3'd4) && byteenable[0];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      m_cnt <= '0;
      m_hi  <= '0;
      m_run <= 1'b1;
    end else begin
      if (m_ctrl_we && writedata[0]) m_cnt <= '0;
      else if (m_run)                m_cnt <= m_cur + 64'd1;
      else                           m_cnt <= m_cur;
      if (m_ctrl_we) m_run <= writedata[1];
      if (read && (address == 3'd2)) m_hi <= m_cur[63:32];
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      n_checks++;
      if (readdatavalid) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rdv: readdatavalid=1 data=%h at cycle %0d, required no transfer",
                   readdata, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (readdata !== mon_e.data || cyc != mon_e.due) begin
            n_fail++;
            $display("FAIL %s: got data=%h cycle=%0d, required data=%h cycle=%0d",
                     mon_e.name, readdata, cyc, mon_e.data, mon_e.due);
          end
        end
      end else if (readdata !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_data: readdata=%h while readdatavalid=0, required 0", readdata);
      end
    end
  end

  // src: 0 = value e, 1 = model low word, 2 = model shadow high word
  task automatic do_read(input logic [2:0] a, input logic [31:0] e, input int src, input string nm);
    logic [31:0] x;
    @(negedge clock);
    read = 1'b1; write = 1'b0; address = a;
    x = (src == 1) ? m_cur[31:0] : (src == 2) ? m_hi : e;
    sb.push_back('{x, cyc + RL, nm});
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    read = 1'b0; write = 1'b1; address = a; writedata = d; byteenable = be;
  endtask

  task automatic bus_idle();
    @(negedge clock);
    read = 1'b0; write = 1'b0; byteenable = '0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d reads outstanding, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0 || readdatavalid3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdv=%b data=%h rdv3=%b, required 0 0 0",
               readdatavalid, readdata, readdatavalid3);
    end
    @(negedge clock);
    reset_n = 1'b1;
    do_read(3'd0, ID, 0, "id");
    do_read(3'd1, TS, 0, "timestamp");
    do_read(3'd7, 32'h0, 0, "unmapped7");
    bus_idle();
    do_read(3'd3, 32'h0, 0, "hi_reset");
    do_read(3'd4, 32'h2, 0, "ctrl_reset");
    do_read(3'd5, 32'h0, 0, "scr0_reset");
    do_read(3'd6, 32'h0, 0, "scr1_reset");
    do_read(3'd2, 32'h0, 1, "lo_after_reset");
    bus_idle();
    wait_drain("reset");
  endtask

  task automatic test_snapshot();
    @(negedge clock);
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
    m_preload_val = 64'h0000_0000_FFFF_FFFE;
    m_preload = 1'b1;
    read = 1'b1; write = 1'b0; address = 3'd2;
    sb.push_back('{32'hFFFF_FFFE, cyc + RL, "snap_lo"});
    #1 release dut.cnt_q;
    @(posedge clock);
    #1 m_preload = 1'b0;
    bus_idle();
    repeat (4) @(negedge clock);
    do_read(3'd3, 32'h0, 0, "snap_hi_before_carry");
    do_read(3'd2, 32'h0, 1, "snap_lo_again");
    do_read(3'd3, 32'h1, 0, "snap_hi_after_carry");
    bus_idle();
    wait_drain("snapshot");
  endtask

  task automatic test_scratch();
    do_write(3'd5, 32'h1122_3344, 4'b1111);
    do_write(3'd5, 32'hAABB_CCDD, 4'b0101);
    do_write(3'd7, 32'hDEAD_BEEF, 4'b1111);
    do_read(3'd5, 32'h11BB_33DD, 0, "scr0_bytes");
    do_read(3'd6, 32'h0, 0, "scr1_untouched");
    do_read(3'd7, 32'h0, 0, "unmapped_write");
    bus_idle();
    wait_drain("scratch");
  endtask

  task automatic test_control();
    do_write(3'd4, 32'h0, 4'b1111);
    do_read(3'd2, 32'h0, 1, "lo_stopped_a");
    do_read(3'd4, 32'h0, 0, "ctrl_run0");
    bus_idle();
    repeat (8) @(negedge clock);
    do_read(3'd2, 32'h0, 1, "lo_stopped_b");
    bus_idle();
    wait_drain("control_stop");
    do_write(3'd4, 32'h3, 4'b1111);
    bus_idle();
    @(negedge clock);
    do_read(3'd2, 32'h2, 0, "lo_after_clear_run");
    do_write(3'd4, 32'h0, 4'b1110);
    do_read(3'd4, 32'h2, 0, "ctrl_be0_gate");
    do_write(3'd4, 32'h1, 4'b1111);
    bus_idle();
    repeat (2) @(negedge clock);
    do_read(3'd2, 32'h0, 0, "lo_clear_held");
    do_read(3'd4, 32'h0, 0, "ctrl_clear_reads0");
    do_write(3'd4, 32'h2, 4'b0001);
    bus_idle();
    wait_drain("control");
  endtask

  task automatic test_reset_inflight();
    int c;
    logic exp_v;
    @(negedge clock);
    read = 1'b1; write = 1'b0; address = 3'd0;
    c = cyc;
    sb.push_back('{ID, c + RL, "lat3_companion"});
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      read = 1'b0;
      exp_v = (cyc == c + RL3);
      n_checks++;
      if (readdatavalid3 !== exp_v || (exp_v && readdata3 !== ID)) begin
        n_fail++;
        $display("FAIL lat3_pulse: cycle=%0d rdv3=%b data3=%h, required rdv3=%b data3=%h",
                 cyc, readdatavalid3, readdata3, exp_v, ID);
      end
    end
    wait_drain("lat3");
    @(negedge clock);
    read = 1'b1; address = 3'd5;
    @(negedge clock);
    read = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (readdatavalid !== 1'b0 || readdatavalid3 !== 1'b0 || readdata3 !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: rdv=%b rdv3=%b data3=%h, required 0 0 0",
               readdatavalid, readdatavalid3, readdata3);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      n_checks++;
      if (readdatavalid3 !== 1'b0) begin
        n_fail++;
        $display("FAIL inflight_discard: rdv3=%b after release, required 0", readdatavalid3);
      end
    end
    do_read(3'd4, 32'h2, 0, "ctrl_after_reset");
    do_read(3'd5, 32'h0, 0, "scr0_after_reset");
    do_read(3'd3, 32'h0, 0, "hi_after_reset");
    bus_idle();
    wait_drain("reset_inflight");
  endtask

  task automatic test_collision();
    @(negedge clock);
    read = 1'b1; write = 1'b1; address = 3'd5; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
    sb.push_back('{32'h0, cyc + RL, "collision_old"});
    do_read(3'd5, 32'hFFFF_FFFF, 0, "collision_new");
    bus_idle();
    wait_drain("collision");
  endtask

  task automatic test_back_to_back();
    do_write(3'd6, 32'h1234_5678, 4'b0011);
    do_read(3'd6, 32'h0000_5678, 0, "b2b_scr1");
    do_read(3'd4, 32'h2, 0, "b2b_ctrl");
    do_read(3'd0, ID, 0, "b2b_id");
    do_read(3'd2, 32'h0, 1, "b2b_lo");
    do_read(3'd3, 32'h0, 2, "b2b_hi");
    do_read(3'd1, TS, 0, "b2b_ts");
    bus_idle();
    wait_drain("back_to_back");
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_scratch();
    test_control();
    test_reset_inflight();
    test_collision();
    test_back_to_back();
    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sysid_ext_slave.md
# sysid_ext_slave

Parametrised system-identification slave on the HPS lightweight Avalon-MM bridge. It returns a build ID and a build timestamp, and provides a 64-bit free-running uptime counter that software reads coherently through a snapshot mechanism. It also provides writable scratch registers for bridge sanity checks. Read latency is fixed and configurable, with an explicit readdatavalid.

## Interface
Parameters:
- ID_VALUE, 32'h0000_0000, value returned at word 0
- TIMESTAMP_VALUE, 32'h0000_0000, build time (Unix seconds) returned at word 1
- NUM_SCRATCH, 2, number of scratch registers, legal 1..3
- READ_LATENCY, 1, cycles from read strobe to readdatavalid, legal 1..3

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address
- read  in  1  read strobe, one transfer per asserted cycle
- write  in  1  write strobe, one transfer per asserted cycle
- writedata  in  32  write data
- byteenable  in  4  byte lanes for writes
- readdata  out  32  read data, valid only when readdatavalid=1, otherwise 0
- readdatavalid  out  1  one-cycle pulse per accepted read

## Operation
No waitrequest: every strobe is accepted in the cycle it is asserted.

Word map:
- 0 ID: RO, ID_VALUE.
- 1 TIMESTAMP: RO, TIMESTAMP_VALUE.
- 2 UPTIME_LO: RO, counter[31:0]. Reading it also loads hi_shadow <= counter[63:32] from the same cycle.
- 3 UPTIME_HI: RO, hi_shadow.
- 4 CONTROL:
  - bit1 RUN: RW, reset 1.
  - bit0 CLEAR: write-1 pulse, always reads 0.
  - Bits 31:2 read 0.
  - A write takes effect only when byteenable[0]=1.
- 5..4+NUM_SCRATCH SCRATCHn: RW, reset 0, per-byte write under byteenable.
- Unmapped words read 0, and writes to them are ignored.

Uptime counter:
- 64-bit. It increments by 1 every cycle while RUN=1 and holds while RUN=0.
- It wraps from 2^64-1 to 0 without a flag.
- CLEAR has priority over increment: the counter is 0 in the cycle after the write, then resumes counting if RUN=1.
- A write of CLEAR=1 together with RUN=0 leaves the counter 0 and held.

Simultaneous read and write in the same cycle:
- Both are performed.
- The read returns the pre-write value of the target register.

## Timing
- Reset values: readdata=0, readdatavalid=0, counter=0, hi_shadow=0, RUN=1, all SCRATCH=0. Reset asserted mid-operation clears all of these and discards every in-flight read; no readdatavalid is issued for it after release.
- Read latency:
  - A read sampled at rising edge T produces readdatavalid=1 and readdata in the cycle following edge T+READ_LATENCY-1 (latency 1 = data in the next cycle).
  - The return is a READ_LATENCY-deep pipeline of {valid, data}.
  - Register values are captured at edge T. Data is not re-read at the output.
- Back-to-back reads on consecutive cycles give consecutive readdatavalid pulses, in order, with no bubbles.
- Writes update the register at the sampling edge and are visible to a read sampled at the next edge.
- Snapshot coherence: for a UPTIME_LO read at edge T followed by any later UPTIME_HI read, {HI, LO} equals the counter value at edge T. This holds even if a carry out of bit 31 happens between the two reads.
- UPTIME_LO returns the counter value before its increment at edge T.

## Test plan
- Reset/ID:
  - Stimulus: ID_VALUE=32'h5D1C_A14E, TIMESTAMP_VALUE=32'h6554_3210, READ_LATENCY=2. Read words 0, 1, 7 back-to-back.
  - Required response: readdatavalid on 3 consecutive cycles starting 2 cycles after the first read, with data 5D1C_A14E, 6554_3210, 0.
- Snapshot across carry:
  - Stimulus: preload the counter to 0x0000_0000_FFFF_FFFE through the bench force path. Read LO, wait 5 cycles, read HI.
  - Required response: LO=FFFF_FFFE, HI=0.
  - Stimulus: immediately read LO again, then HI.
  - Required response: HI=1.
- Scratch byte enables:
  - Stimulus: write 0x1122_3344 to word 5 with byteenable 4'b1111, then 0xAABB_CCDD with byteenable 4'b0101.
  - Required response: readback 0x11BB_33DD, and word 6 still 0.
- Control:
  - Stimulus: write 0x0 (RUN=0), read LO twice 10 cycles apart.
  - Required response: equal values.
  - Stimulus: write 0x3.
  - Required response: LO read 3 cycles later is ≤3 and nonzero per latency math.
- Collision/reset:
  - Stimulus: read and write word 5 in the same cycle (old value 0x0, new value 0xFFFF_FFFF).
  - Required response: readdata 0. A next-cycle read returns FFFF_FFFF.
  - Stimulus: assert reset_n=0 while a READ_LATENCY=3 read is in flight.
  - Required response: no readdatavalid after release.
